adc_scan_ctrl: RTL and testbench
================================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clock cycles (SCLK = 12.5 MHz at 50 MHz), legal range 2..255.
REQ-002 SHALL have parameter TCONV, default 80: ADC_CS_N (CONVST) high time in cycles (1.6 us at 50 MHz), legal range 1..1023.
REQ-003 SHALL have parameter TGAP, default 4: ADC_CS_N low time between end of shift and next CONVST rise, legal range 1..255.
REQ-004 CLOCK_50  in  1  sole clock; all state changes on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  1 = scan continuously; 0 = stop after the current frame.
REQ-007 chan_mask  in  8  channels included in the scan; bit n = CH n.
REQ-008 uni  in  1  1 = unipolar, 0 = bipolar coding; sent as UNI bit.
REQ-009 ADC_CS_N  out  1  LTC2308 CONVST; a rising edge starts a conversion.
REQ-010 ADC_SCLK  out  1  serial clock to ADC.
REQ-011 ADC_DIN  out  1  6-bit config word, MSB first.
REQ-012 ADC_DOUT  in  1  12-bit result, MSB first.
REQ-013 result_valid  out  1  result_data/result_chan hold a result.
REQ-014 result_ready  in  1  consumer accepts when valid&&ready.
REQ-015 result_data  out  12  conversion code.
REQ-016 result_chan  out  3  channel the code belongs to.
REQ-017 overrun  out  1  sticky: an unaccepted result was overwritten.
REQ-018 clear_overrun  in  1  synchronous clear of overrun.
REQ-019 busy  out  1  high in any state except IDLE.

Function
REQ-020 FSM states: IDLE, CONV, SHIFT, GAP; IDLE->CONV when enable=1 and chan_mask!=0; CONV->SHIFT after TCONV cycles; SHIFT->GAP after 12 SCLK periods; GAP->CONV after TGAP cycles if enable=1 and chan_mask!=0, else GAP->IDLE.
REQ-021 ADC_CS_N: 1 in CONV, 0 in IDLE/SHIFT/GAP; SCLK: 0 outside SHIFT.
REQ-022 SHIFT: 12 periods of 2*CLK_DIV cycles; SCLK low for the first CLK_DIV cycles of each period; DIN updated on SCLK falling edge (bit 11 valid at SHIFT entry); DOUT sampled on SCLK rising edge.
REQ-023 Config word {S/D,O/S,S1,S0,UNI,SLP} = {1, ch[0], ch[2], ch[1], uni, 0}, driven on DIN bits 11..6; DIN = 0 for bits 5..0.
REQ-024 Channel selection: round-robin over set bits of chan_mask, next = lowest set bit strictly above current with wrap; first channel after reset = lowest set bit; chan_mask and uni sampled at CONV entry only.
REQ-025 DOUT in frame k is the result of the config sent in frame k-1; result tagged with the channel sent in frame k-1.
REQ-026 First frame after leaving IDLE SHALL NOT produce a result (no valid config yet).
REQ-027 Result registered on the cycle of the 12th SCLK rising edge + 1; result_valid asserts that cycle.
REQ-028 result_valid held, data/chan stable, until valid&&ready; then valid deasserts next cycle unless a new result lands the same cycle.
REQ-029 New result while valid=1 and ready=0: new result replaces old, overrun set to 1.
REQ-030 New result and accept in the same cycle: valid stays 1 with new data, overrun unchanged.
REQ-031 clear_overrun and an overrun event in the same cycle: overrun stays 1.
REQ-032 enable dropped mid-frame: current frame completes including its result; no further CONV.
REQ-033 Frame length = TCONV + 24*CLK_DIV + TGAP cycles (132 with defaults).

Reset
REQ-034 RESET_N low SHALL immediately force IDLE, ADC_CS_N=0, ADC_SCLK=0, ADC_DIN=0, result_valid=0, result_data=0, result_chan=0, overrun=0, busy=0, round-robin pointer to "none" (next pick = lowest set bit), first-frame discard armed; holds mid-frame too.

Verification
V1 Reset, enable=1, mask=0x01, uni=1, ADC model returns 0xABC -> frame 1 no valid; frame 2 result_data=0xABC, result_chan=0; DIN frame 1 = 6'b100010.
V2 mask=0x85 -> channel sequence sent 0,2,7,0,2; result_chan sequence 0,2,7,0 starting frame 2; CONVST rises every 132 cycles.
V3 ready held 0 across two results -> second replaces first, overrun=1; clear_overrun pulse -> overrun=0; clear coincident with new overrun -> overrun=1.
V4 enable deasserted during SHIFT -> frame completes, result delivered, then IDLE, busy=0, CS_N=0, no further CONVST edge.
V5 RESET_N pulsed low mid-SHIFT -> all outputs at reset values same cycle; after release and enable=1, first frame again yields no result.
V6 CLK_DIV=4, TCONV=10, TGAP=1 -> SCLK period 8 cycles, frame 107 cycles; mask=0 with enable=1 -> stays IDLE, busy=0.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Scan controller for an LTC2308-style SAR ADC: round-robins over the enabled channels
// and delivers each conversion code through a valid/ready result register.
module adc_scan_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int TCONV   = 80,
    parameter int TGAP    = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic        uni,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [11:0] result_data,
    output logic [2:0]  result_chan,
    output logic        overrun,
    input  logic        clear_overrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;

    localparam logic [9:0] CONV_LAST = 10'(TCONV - 1);
    localparam logic [9:0] GAP_LAST  = 10'(TGAP - 1);
    localparam logic [8:0] DIV_RISE  = 9'(CLK_DIV);
    localparam logic [8:0] DIV_LAST  = 9'(2 * CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [8:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [10:0] sr_q, sr_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        ptr_ok_q, ptr_ok_d;
    logic        cur_uni_q, cur_uni_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic        prev_ok_q, prev_ok_d;
    logic        valid_q, valid_d;
    logic [11:0] data_q, data_d;
    logic [2:0]  chan_q, chan_d;
    logic        ovr_q, ovr_d;

    logic [7:0]  above;
    logic [7:0]  cand;
    logic [2:0]  pick;
    logic [5:0]  cfg;
    logic        new_res;
    logic        start_ok;

    // Enabled channels strictly above the one sent last; empty until a channel has been sent.
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
        assign above[gi] = chan_mask[gi] && ptr_ok_q && (gi > int'(cur_ch_q));
    end

    always_comb begin
        cand = (above != 8'd0) ? above : chan_mask;
        pick = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) pick = 3'(i);
        end
    end

    assign start_ok = enable && (chan_mask != 8'd0);
    assign cfg      = {1'b1, cur_ch_q[0], cur_ch_q[2], cur_ch_q[1], cur_uni_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        cur_ch_d  = cur_ch_q;
        ptr_ok_d  = ptr_ok_q;
        cur_uni_d = cur_uni_q;
        prev_ch_d = prev_ch_q;
        prev_ok_d = prev_ok_q;
        new_res   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d   = CONV;
                    cnt_d     = 10'd0;
                    cur_ch_d  = pick;
                    ptr_ok_d  = 1'b1;
                    cur_uni_d = uni;
                    prev_ok_d = 1'b0;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = SHIFT;
                    div_d   = 9'd0;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            SHIFT: begin
                div_d = div_q + 9'd1;
                if (div_q == DIV_RISE) begin
                    sr_d = {sr_q[9:0], ADC_DOUT};
                    // DOUT carries the answer to the previous frame's config word.
                    if (bit_q == 4'd11 && prev_ok_q) new_res = 1'b1;
                end
                if (div_q == DIV_LAST) begin
                    div_d = 9'd0;
                    if (bit_q == 4'd11) begin
                        state_d   = GAP;
                        cnt_d     = 10'd0;
                        prev_ch_d = cur_ch_q;
                        prev_ok_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (start_ok) begin
                        state_d   = CONV;
                        cnt_d     = 10'd0;
                        cur_ch_d  = pick;
                        ptr_ok_d  = 1'b1;
                        cur_uni_d = uni;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ovr_d   = ovr_q;
        if (new_res) begin
            valid_d = 1'b1;
            data_d  = {sr_q, ADC_DOUT};
            chan_d  = prev_ch_q;
        end else if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
        // An overwrite wins over a simultaneous clear.
        if (new_res && valid_q && !result_ready) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            div_q     <= 9'd0;
            bit_q     <= 4'd0;
            sr_q      <= 11'd0;
            cur_ch_q  <= 3'd0;
            ptr_ok_q  <= 1'b0;
            cur_uni_q <= 1'b0;
            prev_ch_q <= 3'd0;
            prev_ok_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 12'd0;
            chan_q    <= 3'd0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            cur_ch_q  <= cur_ch_d;
            ptr_ok_q  <= ptr_ok_d;
            cur_uni_q <= cur_uni_d;
            prev_ch_q <= prev_ch_d;
            prev_ok_q <= prev_ok_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ADC_CS_N     = (state_q == CONV);
    assign ADC_SCLK     = (state_q == SHIFT) && (div_q >= DIV_RISE);
    assign ADC_DIN      = (state_q == SHIFT) && (bit_q < 4'd6) && cfg[3'd5 - bit_q[2:0]];
    assign result_valid = valid_q;
    assign result_data  = data_q;
    assign result_chan  = chan_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: an ADC model feeds queued codes, expected results
// and config words are queued by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] d;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  chan_mask = 8'd0;
    logic        uni = 1'b0;
    logic        result_ready = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        ADC_DOUT;
    logic        ADC_CS_N, ADC_SCLK, ADC_DIN, result_valid, overrun, busy;
    logic [11:0] result_data;
    logic [2:0]  result_chan;

    logic        en6 = 1'b0, ready6 = 1'b1, clr6 = 1'b0, dout6 = 1'b0, uni6 = 1'b0;
    logic [7:0]  mask6 = 8'd0;
    logic        cs6, sclk6, din6, valid6, ovr6, busy6;
    logic [11:0] data6;
    logic [2:0]  chan6;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [11:0] din_exp[$];
    logic [11:0] adc_codes[$];
    int          cs_times[$];
    int          cs6_times[$];
    int          sclk6_times[$];
    logic [11:0] adc_cur = 12'd0;
    logic [3:0]  adc_idx = 4'd0;

    assign ADC_DOUT = adc_cur[adc_idx];

    adc_scan_ctrl dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .enable(enable), .chan_mask(chan_mask),
        .uni(uni), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN),
        .ADC_DOUT(ADC_DOUT), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_chan(result_chan), .overrun(overrun),
        .clear_overrun(clear_overrun), .busy(busy)
    );

    adc_scan_ctrl #(.CLK_DIV(4), .TCONV(10), .TGAP(1)) dut6 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .enable(en6), .chan_mask(mask6),
        .uni(uni6), .ADC_CS_N(cs6), .ADC_SCLK(sclk6), .ADC_DIN(din6),
        .ADC_DOUT(dout6), .result_valid(valid6), .result_ready(ready6),
        .result_data(data6), .result_chan(chan6), .overrun(ovr6),
        .clear_overrun(clr6), .busy(busy6)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: scoreboard pops on handshake, DIN word capture, ADC model, edge timestamps.
    initial begin
        logic        sclk_prev, cs_prev, sclk6_prev, cs6_prev;
        logic [11:0] din_sh, want;
        int          din_n;
        exp_t        e;
        sclk_prev = 1'b0; cs_prev = 1'b0; sclk6_prev = 1'b0; cs6_prev = 1'b0;
        din_sh = 12'd0; din_n = 0;
        forever begin
            @(negedge CLOCK_50);
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual chan=%0d data=%03h required none",
                             result_chan, result_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("RESULT chan=%0d data=%03h expect chan=%0d data=%03h",
                             result_chan, result_data, e.ch, e.d);
                    chk("sb_result", {17'd0, result_chan, result_data}, {17'd0, e.ch, e.d});
                end
            end
            if (ADC_SCLK && !sclk_prev) begin
                din_sh = {din_sh[10:0], ADC_DIN};
                din_n++;
                if (din_n == 12 && din_exp.size() > 0) begin
                    want = din_exp.pop_front();
                    $display("DINWORD got=%03h expect=%03h", din_sh, want);
                    chk("din_word", {20'd0, din_sh}, {20'd0, want});
                end
            end
            if (!ADC_SCLK && sclk_prev && adc_idx != 4'd0) adc_idx = adc_idx - 4'd1;
            if (ADC_CS_N && !cs_prev) begin
                cs_times.push_back(cyc);
                din_n = 0;
                adc_cur = (adc_codes.size() > 0) ? adc_codes.pop_front() : 12'd0;
                adc_idx = 4'd11;
            end
            if (cs6 && !cs6_prev) cs6_times.push_back(cyc);
            if (sclk6 && !sclk6_prev) sclk6_times.push_back(cyc);
            sclk_prev = ADC_SCLK; cs_prev = ADC_CS_N;
            sclk6_prev = sclk6; cs6_prev = cs6;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_cs(input int n);
        int k = 0;
        while (cs_times.size() < n && k < 2000) begin tick(1); k++; end
        if (cs_times.size() < n) timeout("wait_convst");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin tick(1); k++; end
        chk("went_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_data_change();
        logic [11:0] old;
        int k = 0;
        old = result_data;
        while (result_data == old && k < 400) begin tick(1); k++; end
        if (result_data == old) timeout("wait_new_result");
    endtask

    task automatic restart();
        RESET_N = 1'b0;
        enable = 1'b0;
        tick(2);
        exp_q.delete(); din_exp.delete(); adc_codes.delete(); cs_times.delete();
        RESET_N = 1'b1;
        tick(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"},   {31'd0, ADC_CS_N}, 32'd0);
        chk({tag, "_sclk"},   {31'd0, ADC_SCLK}, 32'd0);
        chk({tag, "_din"},    {31'd0, ADC_DIN}, 32'd0);
        chk({tag, "_valid"},  {31'd0, result_valid}, 32'd0);
        chk({tag, "_data"},   {20'd0, result_data}, 32'd0);
        chk({tag, "_chan"},   {29'd0, result_chan}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tick(3);
        chk_reset_outputs("reset");

        // Single channel, unipolar: first frame discarded, second returns 0xABC on CH0.
        restart();
        adc_codes = '{12'h123, 12'hABC};
        din_exp = '{12'h880, 12'h880};
        exp_q.push_back('{ch: 3'd0, d: 12'hABC});
        chan_mask = 8'h01; uni = 1'b1; result_ready = 1'b1; enable = 1'b1;
        wait_cs(2);
        tick(100);
        enable = 1'b0;
        wait_idle();
        chk("idle_cs_n", {31'd0, ADC_CS_N}, 32'd0);
        chk("idle_sclk", {31'd0, ADC_SCLK}, 32'd0);
        tick(300);
        chk("no_more_convst", cs_times.size(), 32'd2);
        chk("sb_drained_v1", exp_q.size(), 32'd0);

        // Round-robin over CH0, CH2, CH7 with bipolar coding.
        restart();
        adc_codes = '{12'h111, 12'h5A5, 12'h0FF, 12'hF00, 12'h800};
        din_exp = '{12'h800, 12'h900, 12'hF00, 12'h800, 12'h900};
        exp_q.push_back('{ch: 3'd0, d: 12'h5A5});
        exp_q.push_back('{ch: 3'd2, d: 12'h0FF});
        exp_q.push_back('{ch: 3'd7, d: 12'hF00});
        exp_q.push_back('{ch: 3'd0, d: 12'h800});
        chan_mask = 8'h85; uni = 1'b0; result_ready = 1'b1; enable = 1'b1;
        wait_cs(5);
        tick(100);
        enable = 1'b0;
        wait_idle();
        tick(5);
        for (int i = 0; i < 4; i++) begin
            if (cs_times.size() > i + 1)
                chk("convst_period", cs_times[i+1] - cs_times[i], 32'd132);
            else
                timeout("convst_period");
        end
        chk("sb_drained_v2", exp_q.size(), 32'd0);
        chk("din_drained_v2", din_exp.size(), 32'd0);

        // Overrun: replacement, sticky, clear, and clear coinciding with a new overwrite.
        restart();
        adc_codes = '{12'h001, 12'h222, 12'h333, 12'h444, 12'h555};
        chan_mask = 8'h01; uni = 1'b1; result_ready = 1'b0; enable = 1'b1;
        wait_data_change();
        chk("first_held", {20'd0, result_data}, 32'h222);
        chk("no_overrun_yet", {31'd0, overrun}, 32'd0);
        wait_data_change();
        chk("replaced_data", {20'd0, result_data}, 32'h333);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        exp_q.push_back('{ch: 3'd0, d: 12'h333});
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        chk("valid_dropped", {31'd0, result_valid}, 32'd0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);
        wait_data_change();
        chk("no_overrun_when_empty", {31'd0, overrun}, 32'd0);
        clear_overrun = 1'b1;
        wait_data_change();
        clear_overrun = 1'b0;
        chk("overrun_beats_clear", {31'd0, overrun}, 32'd1);
        enable = 1'b0;
        tick(1);
        chk("overrun_holds", {31'd0, overrun}, 32'd1);
        exp_q.push_back('{ch: 3'd0, d: 12'h555});
        result_ready = 1'b1;
        wait_idle();
        tick(5);
        chk("sb_drained_v3", exp_q.size(), 32'd0);

        // Asynchronous reset mid-SHIFT, then the first frame after restart is discarded again.
        restart();
        adc_codes = '{12'h010, 12'h020, 12'h030, 12'h040};
        chan_mask = 8'h01; uni = 1'b1; result_ready = 1'b0; enable = 1'b1;
        wait_cs(4);
        tick(100);
        chk("pre_reset_overrun", {31'd0, overrun}, 32'd1);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick(2);
        exp_q.delete(); adc_codes.delete(); cs_times.delete();
        adc_codes = '{12'hDEA, 12'h0C3};
        exp_q.push_back('{ch: 3'd0, d: 12'h0C3});
        result_ready = 1'b1;
        RESET_N = 1'b1;
        wait_cs(2);
        tick(100);
        enable = 1'b0;
        wait_idle();
        tick(5);
        chk("sb_drained_v5", exp_q.size(), 32'd0);

        // Alternate parameters; empty mask must keep the block idle.
        en6 = 1'b1; mask6 = 8'h00;
        tick(40);
        chk("p6_mask0_busy", {31'd0, busy6}, 32'd0);
        chk("p6_mask0_cs_n", {31'd0, cs6}, 32'd0);
        cs6_times.delete(); sclk6_times.delete();
        mask6 = 8'h01;
        begin
            int k = 0;
            while (cs6_times.size() < 2 && k < 400) begin tick(1); k++; end
        end
        if (cs6_times.size() >= 2 && sclk6_times.size() >= 2) begin
            chk("p6_frame_len", cs6_times[1] - cs6_times[0], 32'd107);
            chk("p6_sclk_period", sclk6_times[1] - sclk6_times[0], 32'd8);
        end else begin
            timeout("p6_frames");
        end
        en6 = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
